// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and defaults for the programmable clock-divider controller.
// Pulled in by the interface, the half-period counter and the top.
package clk_div_ctrl_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Config port of the divider: a new half-period setting offered with valid/ready.
// The controller is the slave; the software-facing side is the master.
interface clk_div_ctrl_if #(
    parameter int CNT_W = clk_div_ctrl_pkg::CNT_W_DEF
) ();

    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/div_halfcnt.sv
// Half-period counter: counts up while enabled and flags the last cycle of a phase
// (count equals the active divide setting), wrapping to zero on that cycle.
module div_halfcnt #(
    parameter int CNT_W = clk_div_ctrl_pkg::CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o = (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider: ratio changes and start/stop take effect
// only at full-period boundaries (end of the low phase).
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int RST_DIV = 0
) (
    input  logic           clk_in,
    input  logic           reset,
    input  logic           run,
    clk_div_ctrl_if.slave  cfg,
    output logic           clk_out,
    output logic           tick,
    output logic           busy
);

    localparam logic [CNT_W-1:0] RST_DIV_V = CNT_W'(RST_DIV);

    state_e           state_q, state_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;

    logic last;
    logic boundary;
    logic accept;
    logic apply;
    logic cnt_clear;
    logic cnt_en;

    div_halfcnt #(
        .CNT_W (CNT_W)
    ) u_halfcnt (
        .clk_in  (clk_in),
        .reset   (reset),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .div_i   (div_act_q),
        .last_o  (last)
    );

    // End of the low phase is the only point where a new period may begin.
    assign boundary = last && !clk_out_q;
    assign accept   = cfg.cfg_valid && !pend_v_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = RUN;
            end
            RUN: begin
                if (boundary) begin
                    state_d = run ? RUN : IDLE;
                end else if (!run) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (boundary) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        apply     = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                clk_out_d = run;
                tick_d    = run;
                apply     = pend_v_q;
            end
            RUN: begin
                cnt_en = 1'b1;
                if (last) begin
                    if (clk_out_q) begin
                        clk_out_d = 1'b0;
                    end else if (run) begin
                        clk_out_d = 1'b1;
                        tick_d    = 1'b1;
                        apply     = pend_v_q;
                    end else begin
                        clk_out_d = 1'b0;
                    end
                end
            end
            STOP: begin
                // Finish the period already in flight; never start another one.
                cnt_en = 1'b1;
                if (last) clk_out_d = 1'b0;
            end
            default: begin
                cnt_clear = 1'b1;
                clk_out_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        div_act_d = apply ? pend_q : div_act_q;
        pend_d    = accept ? cfg.cfg_div : pend_q;
        pend_v_d  = pend_v_q;
        if (accept) begin
            pend_v_d = 1'b1;
        end else if (apply) begin
            pend_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            div_act_q <= RST_DIV_V;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
        end else begin
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            div_act_q <= div_act_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
        end
    end

    assign cfg.cfg_ready = !pend_v_q;
    assign clk_out       = clk_out_q;
    assign tick          = tick_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: fixed vector table, directed stop/restart/reset sequences,
// then random traffic checked against a phase-countdown reference model.
module tb_clk_div_ctrl;

    localparam int CNT_W   = 8;
    localparam int RST_DIV = 0;

    logic clk_in = 1'b0;
    logic reset;
    logic run;
    logic clk_out;
    logic tick;
    logic busy;

    clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg ();

    clk_div_ctrl #(
        .CNT_W   (CNT_W),
        .RST_DIV (RST_DIV)
    ) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .run     (run),
        .cfg     (cfg),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a clock that is either off or running through phases whose
    // length is (div+1); a stop request ends it at the close of a low phase.
    bit m_on, m_stop, m_hi, m_tick;
    int m_left, m_div;
    int pq[$];

    function automatic void m_reset();
        m_on = 0; m_stop = 0; m_hi = 0; m_tick = 0;
        m_left = 0; m_div = RST_DIV;
        pq.delete();
    endfunction

    function automatic void m_edge(input bit r, input bit rn, input bit v, input int d);
        bit acc;
        if (r) begin
            m_reset();
            return;
        end
        acc = v && (pq.size() == 0);
        m_tick = 0;
        if (!m_on) begin
            if (pq.size() != 0) m_div = pq.pop_front();
            if (rn) begin
                m_on = 1; m_stop = 0; m_hi = 1; m_left = m_div + 1; m_tick = 1;
            end
        end else begin
            if (!rn) m_stop = 1;
            m_left--;
            if (m_left == 0) begin
                if (m_hi) begin
                    m_hi = 0; m_left = m_div + 1;
                end else if (m_stop) begin
                    m_on = 0;
                end else begin
                    if (pq.size() != 0) m_div = pq.pop_front();
                    m_hi = 1; m_left = m_div + 1; m_tick = 1;
                end
            end
        end
        if (acc) pq.push_back(d);
    endfunction

    task automatic step(input bit r, input bit rn, input bit v, input int d);
        reset = r;
        run = rn;
        cfg.cfg_valid = v;
        cfg.cfg_div = d[CNT_W-1:0];
        @(posedge clk_in);
        m_edge(r, rn, v, d & ((1 << CNT_W) - 1));
        #1;
        chk("clk_out", clk_out, m_hi);
        chk("tick", tick, m_tick);
        chk("busy", busy, m_on);
        chk("cfg_ready", cfg.cfg_ready, pq.size() == 0);
    endtask

    typedef struct {
        bit r; bit rn; bit v; int d;
        bit e_clk; bit e_tick; bit e_busy; bit e_rdy;
    } vec_t;
    vec_t vq[$];

    function automatic void addv(input bit r, input bit rn, input bit v, input int d,
                                 input bit c, input bit t, input bit b, input bit y, input int n);
        vec_t e;
        e.r = r; e.rn = rn; e.v = v; e.d = d;
        e.e_clk = c; e.e_tick = t; e.e_busy = b; e.e_rdy = y;
        for (int i = 0; i < n; i++) vq.push_back(e);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, cur, minlen, n, ticks;
        bit pre, prev, first, found, rn_r;
        reset = 1'b1; run = 1'b0; cfg.cfg_valid = 1'b0; cfg.cfg_div = '0;
        m_reset();

        // Divide-by-2 out of reset, then a live switch to div 3.
        addv(1,0,0,0, 0,0,0,1, 3);
        addv(0,0,0,0, 0,0,0,1, 1);
        addv(0,1,0,0, 1,1,1,1, 1);
        addv(0,1,0,0, 0,0,1,1, 1);
        addv(0,1,0,0, 1,1,1,1, 1);
        addv(0,1,1,3, 0,0,1,0, 1);
        addv(0,1,0,0, 1,1,1,1, 1);
        addv(0,1,0,0, 1,0,1,1, 3);
        addv(0,1,0,0, 0,0,1,1, 4);
        addv(0,1,0,0, 1,1,1,1, 1);
        addv(0,1,0,0, 1,0,1,1, 3);
        addv(0,1,0,0, 0,0,1,1, 1);
        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].r, vq[i].rn, vq[i].v, vq[i].d);
            chk($sformatf("vec%0d_clk", i), clk_out, vq[i].e_clk);
            chk($sformatf("vec%0d_tick", i), tick, vq[i].e_tick);
            chk($sformatf("vec%0d_busy", i), busy, vq[i].e_busy);
            chk($sformatf("vec%0d_rdy", i), cfg.cfg_ready, vq[i].e_rdy);
        end

        // Back-to-back configs: 1 must wait until 3 has been applied.
        step(0, 1, 1, 3);
        chk("t3_rdy_low", cfg.cfg_ready, 0);
        waited = 0;
        pre = 1'b0;
        while (!pre && waited < 40) begin
            pre = cfg.cfg_ready;
            step(0, 1, 1, 1);
            waited++;
        end
        chk("t3_accepted", pre, 1);
        chk("t3_held_off", waited > 1, 1);
        cur = 0; minlen = 1000; prev = clk_out; first = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step(0, 1, 0, 0);
            if (clk_out == prev) cur++;
            else begin
                if (!first && cur < minlen) minlen = cur;
                first = 1'b0; cur = 1; prev = clk_out;
            end
        end
        chk("t3_min_phase", minlen, 2);

        // Back to div 3, then drop run one cycle into a high phase.
        for (int k = 0; k < 40 && !cfg.cfg_ready; k++) step(0, 1, 0, 0);
        step(0, 1, 1, 3);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(0, 1, 0, 0);
            if (tick && cfg.cfg_ready) begin found = 1'b1; break; end
        end
        chk("t4_sync", found, 1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        n = 0; ticks = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 0);
            n++; ticks += int'(tick);
            if (!busy) break;
        end
        chk("t4_stop_len", n, 6);
        chk("t4_no_tick", ticks, 0);
        chk("t4_clk_low", clk_out, 0);

        // Run reasserted during STOP does not cancel the stop.
        step(0, 1, 0, 0);
        chk("t5_start_tick", tick, 1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        n = 0; ticks = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 0, 0);
            n++; ticks += int'(tick);
            if (!busy) break;
        end
        chk("t5_stop_len", n, 6);
        chk("t5_no_tick", ticks, 0);
        step(0, 1, 0, 0);
        chk("t5_restart_tick", tick, 1);
        chk("t5_restart_busy", busy, 1);

        // Reset mid high phase with a pending config.
        step(0, 1, 1, 5);
        chk("t6_pend", cfg.cfg_ready, 0);
        chk("t6_high", clk_out, 1);
        step(1, 1, 0, 0);
        chk("t6_clk", clk_out, 0);
        chk("t6_tick", tick, 0);
        chk("t6_busy", busy, 0);
        chk("t6_rdy", cfg.cfg_ready, 1);
        step(0, 1, 0, 0);
        chk("t6_start", clk_out, 1);
        step(0, 1, 0, 0);
        chk("t6_rst_div", clk_out, 0);
        step(0, 1, 0, 0);
        chk("t6_rst_div_tick", tick, 1);

        // Random traffic against the model.
        rn_r = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) rn_r = !rn_r;
            step($urandom_range(0, 299) == 0, rn_r, $urandom_range(0, 5) == 0,
                 ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
